// File: rtl/updown_mod_counter.sv
// updown_mod_counter: synchronous up/down counter with programmable modulus,
// enable prescaler, parallel load and wrap-or-saturate boundary behaviour.
// Every state element updates on the same clock edge, so q never glitches.
//
// Parameters:
//   WIDTH     counter width in bits (1..32)
//   MAX_COUNT highest count value; counter ranges 0..MAX_COUNT
//   DIV       prescaler ratio; one step per DIV enabled cycles (1..65535)
//   SATURATE  0 = wrap at the boundary, 1 = hold at the boundary
//
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-high reset of all state
//   en        count enable, feeds the prescaler
//   up_dn     direction (1 = up, 0 = down), used only on a step edge
//   clear     synchronous clear of count, prescaler, tc and ovf
//   load      synchronous parallel load (overrides en and any step)
//   load_val  value to load, clamped to MAX_COUNT
//   q         registered count
//   tc        registered one-cycle pulse following a boundary step
//   ovf       sticky boundary flag, cleared by clear or reset
module updown_mod_counter #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
    parameter int unsigned      DIV       = 1,
    parameter int unsigned      SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam int unsigned   PW       = 16;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam bit            SAT      = (SATURATE != 0);

    logic [PW-1:0]    pre;
    logic [WIDTH-1:0] load_clamped_c;
    logic [WIDTH-1:0] step_q_c;
    logic             step_c;
    logic             boundary_c;

    // Next-count arithmetic; the boundary test precedes the +/-1 so the
    // count never passes through a value above MAX_COUNT.
    always_comb begin
        load_clamped_c = load_val;
        step_q_c       = q;
        step_c         = en && (pre == PRE_LAST);
        boundary_c     = 1'b0;

        if (load_val > MAX_COUNT) begin
            load_clamped_c = MAX_COUNT;
        end

        if (up_dn) begin
            boundary_c = (q == MAX_COUNT);
            if (boundary_c) begin
                step_q_c = SAT ? MAX_COUNT : WIDTH'(0);
            end else begin
                step_q_c = q + WIDTH'(1);
            end
        end else begin
            boundary_c = (q == WIDTH'(0));
            if (boundary_c) begin
                step_q_c = SAT ? WIDTH'(0) : MAX_COUNT;
            end else begin
                step_q_c = q - WIDTH'(1);
            end
        end
    end

    // State update, priority clear > load > step > hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q   <= '0;
            pre <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (clear) begin
            q   <= '0;
            pre <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (load) begin
            q   <= load_clamped_c;
            pre <= '0;
            tc  <= 1'b0;
        end else if (step_c) begin
            q   <= step_q_c;
            pre <= '0;
            tc  <= boundary_c;
            if (boundary_c) begin
                ovf <= 1'b1;
            end
        end else begin
            // en=0 freezes the prescaler in place
            if (en) begin
                pre <= pre + PW'(1);
            end
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter. Four configurations share one
// stimulus stream; a behavioural model (modular arithmetic per instance) is
// compared against every instance on each falling edge, and directed
// sequences pin the model with hand-computed literal values.
module tb_updown_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       clear;
    logic       load;
    logic [7:0] load_val;

    logic [7:0] q0, q1, q2;
    logic [3:0] q3;
    logic [3:0] tcv;
    logic [3:0] ovfv;

    int n_tests = 0;
    int n_fail  = 0;

    // u0: 8-bit full range, wrap    u1: modulus 10, wrap
    // u2: max 100, DIV=4, saturate  u3: 4-bit, max 11, saturate
    updown_mod_counter #(.WIDTH(8), .MAX_COUNT(8'd255), .DIV(1), .SATURATE(0)) u0 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .q(q0), .tc(tcv[0]), .ovf(ovfv[0]));
    updown_mod_counter #(.WIDTH(8), .MAX_COUNT(8'd9), .DIV(1), .SATURATE(0)) u1 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .q(q1), .tc(tcv[1]), .ovf(ovfv[1]));
    updown_mod_counter #(.WIDTH(8), .MAX_COUNT(8'd100), .DIV(4), .SATURATE(1)) u2 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .q(q2), .tc(tcv[2]), .ovf(ovfv[2]));
    updown_mod_counter #(.WIDTH(4), .MAX_COUNT(4'd11), .DIV(1), .SATURATE(1)) u3 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .q(q3), .tc(tcv[3]), .ovf(ovfv[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int maxc(input int i);
        case (i)
            0:       return 255;
            1:       return 9;
            2:       return 100;
            default: return 11;
        endcase
    endfunction

    function automatic int divc(input int i);
        return (i == 2) ? 4 : 1;
    endfunction

    function automatic bit satc(input int i);
        return (i >= 2);
    endfunction

    function automatic int get_q(input int i);
        case (i)
            0:       return int'(q0);
            1:       return int'(q1);
            2:       return int'(q2);
            default: return int'(q3);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: count as an integer in 0..MAX, prescaler as a
    // count of enabled cycles since the last step.
    int mq [4];
    int mp [4];
    bit mtc [4];
    bit movf [4];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 4; i++) begin
            int  nq, np, lv, m;
            bit  ntc, novf, bnd;
            m    = maxc(i);
            nq   = mq[i];
            np   = mp[i];
            ntc  = 1'b0;
            novf = movf[i];
            lv   = (i == 3) ? int'(load_val[3:0]) : int'(load_val);
            if (reset || clear) begin
                nq = 0; np = 0; novf = 1'b0;
            end else if (load) begin
                nq = (lv > m) ? m : lv;
                np = 0;
            end else if (en) begin
                np = mp[i] + 1;
                if (np == divc(i)) begin
                    np  = 0;
                    bnd = up_dn ? (mq[i] == m) : (mq[i] == 0);
                    if (bnd && satc(i))
                        nq = mq[i];
                    else if (up_dn)
                        nq = (mq[i] + 1) % (m + 1);
                    else
                        nq = (mq[i] + m) % (m + 1);
                    ntc  = bnd;
                    novf = novf | bnd;
                end
            end
            mq[i]   <= nq;
            mp[i]   <= np;
            mtc[i]  <= ntc;
            movf[i] <= novf;
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            check($sformatf("u%0d.q", i), 32'(get_q(i)), 32'(mq[i]));
            check($sformatf("u%0d.tc", i), 32'(tcv[i]), 32'(mtc[i]));
            check($sformatf("u%0d.ovf", i), 32'(ovfv[i]), 32'(movf[i]));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic e, input logic u, input logic c, input logic l, input logic [7:0] v);
        en = e; up_dn = u; clear = c; load = l; load_val = v;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1, 0, 0, 8'h00);
        tick();
        tick();
        reset = 1'b0;

        // Reset state, then async reset mid-count from 0x37
        check("reset_q", 32'(q0), 32'd0);
        check("reset_ovf", 32'(ovfv[0]), 32'd0);
        drive(0, 1, 0, 1, 8'h37);
        tick();
        check("load_37", 32'(q0), 32'h37);
        drive(1, 1, 0, 0, 8'h00);
        #2 reset = 1'b1;
        #1;
        check("async_rst_q", 32'(q0), 32'd0);
        check("async_rst_tc", 32'(tcv[0]), 32'd0);
        check("async_rst_ovf", 32'(ovfv[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("count_after_rst_%0d", k), 32'(q0), 32'(k));
        end

        // Up wrap with modulus 10
        drive(0, 1, 0, 1, 8'd8);
        tick();
        drive(1, 1, 0, 0, 8'd0);
        tick();
        check("mod_wrap_q9", 32'(q1), 32'd9);
        check("mod_wrap_tc_lo", 32'(tcv[1]), 32'd0);
        tick();
        check("mod_wrap_q0", 32'(q1), 32'd0);
        check("mod_wrap_tc", 32'(tcv[1]), 32'd1);
        check("mod_wrap_ovf", 32'(ovfv[1]), 32'd1);
        drive(0, 1, 0, 0, 8'd0);
        tick();
        check("mod_wrap_tc_end", 32'(tcv[1]), 32'd0);

        // Down saturate on u3
        drive(0, 0, 0, 1, 8'd1);
        tick();
        drive(1, 0, 0, 0, 8'd0);
        tick();
        check("sat_dn_q_1", 32'(q3), 32'd0);
        check("sat_dn_tc_1", 32'(tcv[3]), 32'd0);
        tick();
        check("sat_dn_q_2", 32'(q3), 32'd0);
        check("sat_dn_tc_2", 32'(tcv[3]), 32'd1);
        check("sat_dn_ovf", 32'(ovfv[3]), 32'd1);
        tick();
        check("sat_dn_tc_3", 32'(tcv[3]), 32'd1);
        drive(0, 0, 0, 0, 8'd0);
        tick();
        check("sat_dn_tc_off", 32'(tcv[3]), 32'd0);

        // Prescaler DIV=4: steps on edges 4, 8, 12
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1, 1, 0, 0, 8'd0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3)  check("pre_e3", 32'(q2), 32'd0);
            if (k == 4)  check("pre_e4", 32'(q2), 32'd1);
            if (k == 7)  check("pre_e7", 32'(q2), 32'd1);
            if (k == 8)  check("pre_e8", 32'(q2), 32'd2);
            if (k == 12) check("pre_e12", 32'(q2), 32'd3);
        end

        // Prescaler with en=0 for 5 cycles after edge 5: second step moves to edge 13
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            en = !(k >= 6 && k <= 10);
            tick();
            if (k == 12) check("pre_gap_e12", 32'(q2), 32'd1);
            if (k == 13) check("pre_gap_e13", 32'(q2), 32'd2);
        end

        // Load+clear: clear wins and drops a set ovf
        drive(0, 1, 0, 1, 8'd0);
        tick();
        drive(1, 0, 0, 0, 8'd0);
        tick();
        check("pre_clr_ovf", 32'(ovfv[0]), 32'd1);
        drive(0, 1, 1, 1, 8'h55);
        tick();
        check("ldclr_q", 32'(q0), 32'd0);
        check("ldclr_ovf", 32'(ovfv[0]), 32'd0);

        // Load clamp
        drive(0, 1, 0, 1, 8'hFF);
        tick();
        check("clamp_u2", 32'(q2), 32'd100);
        check("clamp_u3", 32'(q3), 32'd11);
        check("clamp_u0", 32'(q0), 32'd255);

        // Load on a step edge: step discarded, prescaler restarted
        drive(1, 1, 0, 0, 8'd0);
        tick(); tick(); tick();
        drive(1, 1, 0, 1, 8'h20);
        tick();
        check("ld_step_u2", 32'(q2), 32'h20);
        check("ld_step_u0", 32'(q0), 32'h20);
        drive(1, 1, 0, 0, 8'd0);
        tick();
        check("ld_step_u0_next", 32'(q0), 32'h21);
        check("ld_step_u2_hold", 32'(q2), 32'h20);

        // Sticky ovf through 20 ordinary steps, then clear
        drive(0, 1, 1, 0, 8'd0);
        tick();
        drive(0, 1, 0, 1, 8'd255);
        tick();
        drive(1, 1, 0, 0, 8'd0);
        tick();
        check("sticky_wrap_q", 32'(q0), 32'd0);
        check("sticky_wrap_ovf", 32'(ovfv[0]), 32'd1);
        for (int k = 0; k < 20; k++) tick();
        check("sticky_q20", 32'(q0), 32'd20);
        check("sticky_ovf", 32'(ovfv[0]), 32'd1);
        drive(1, 1, 1, 0, 8'd0);
        tick();
        check("sticky_clr_q", 32'(q0), 32'd0);
        check("sticky_clr_ovf", 32'(ovfv[0]), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'hFF;
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 24) == 0), v);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter with programmable modulus, prescaler, parallel load, and wrap or saturate mode. It supersedes the 8-bit asynchronous ripple counter used for event and tick counting in the Cloud-Car datapath. All state changes on a single clock edge, so downstream logic sees a glitch-free count. It also adds terminal-count and sticky overflow reporting.

## Interface
Parameters:
- WIDTH, 8: counter width in bits (1..32).
- MAX_COUNT, 2**WIDTH-1: highest count value; the counter ranges 0..MAX_COUNT. Must be < 2**WIDTH.
- DIV, 1: prescaler ratio; one count step per DIV enabled cycles (1..65535).
- SATURATE, 0: 0 = wrap at the boundary, 1 = hold at the boundary.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state immediately.
- en  in  1  count enable; feeds the prescaler.
- up_dn  in  1  direction: 1 = up, 0 = down; sampled only on a step cycle.
- clear  in  1  synchronous clear of count, prescaler and ovf.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load; clamped to MAX_COUNT.
- q  out  WIDTH  current count, registered.
- tc  out  1  registered one-cycle pulse after a boundary step.
- ovf  out  1  sticky flag, set by any boundary step.

## Operation
- Reset (async assert): q=0, tc=0, ovf=0, prescaler=0. Outputs hold these values while reset is high. The first update occurs on the first rising clk edge after reset deasserts.
- Priority per edge: clear > load > step > hold.
- Clear: q=0, prescaler=0, ovf=0, tc=0.
- Load:
  - q=min(load_val, MAX_COUNT); prescaler=0; tc=0.
  - ovf is unchanged.
  - A load ignores en.
- Prescaler:
  - The prescaler is an internal counter over 0..DIV-1. It advances only when en=1 and neither clear nor load is active.
  - A step occurs on an edge where en=1 and prescaler==DIV-1; the prescaler then returns to 0.
  - With DIV=1, every enabled cycle is a step.
  - en=0 freezes the prescaler without resetting it.
- Step up:
  - If q<MAX_COUNT, then q=q+1.
  - If q==MAX_COUNT, then q=0 (SATURATE=0) or q stays at MAX_COUNT (SATURATE=1). In both cases this is a boundary step.
- Step down:
  - If q>0, then q=q-1.
  - If q==0, then q=MAX_COUNT (SATURATE=0) or q stays at 0 (SATURATE=1). This is a boundary step.
- Boundary step: sets tc=1 for the following cycle only and sets ovf=1. ovf stays set until the next clear or reset.
- Arithmetic: the count is unsigned and computed at WIDTH bits. The comparison against MAX_COUNT happens before the increment, so no intermediate value exceeds MAX_COUNT. When MAX_COUNT < 2**WIDTH-1, the count wraps at MAX_COUNT, not at 2**WIDTH.
- Saturated hold: a repeated step at the boundary re-pulses tc on each step.

## Timing
- q, tc and ovf are all registered; there are no combinational paths from inputs to outputs.
- Load and clear: the new q is visible 1 cycle after the edge on which they were sampled.
- Step latency: with en held high from prescaler=0, the first change of q appears after DIV edges.
- tc: high for exactly the one cycle following a boundary-step edge, and low on every other cycle.
- Simultaneous load+clear: clear wins and q=0.
- Simultaneous load+step: load wins, and the step is discarded rather than deferred.
- up_dn change between steps: no effect until the next step edge.
- Reset mid-count or mid-prescale: all state returns to 0 immediately. A pending tc is cancelled.

## Test plan
- Reset check: with WIDTH=8, DIV=1, SATURATE=0, assert reset asynchronously while en=1 and q=0x37 → q, tc and ovf read 0 before the next edge. After release, q counts 1,2,3 on successive edges.
- Up wrap with modulus: with MAX_COUNT=9, load 8, then 2 enabled up steps → q=9, then q=0. tc is high for the one cycle after q=0 appears and ovf=1.
- Down saturate: with SATURATE=1, load 1, then 3 down steps → q=0,0,0. tc pulses after the 2nd and 3rd steps and ovf=1.
- Prescaler: with DIV=4 and en=1 for 12 cycles from reset → q steps 0→1→2→3 on edges 4, 8 and 12. Insert en=0 for 5 cycles between edges 5 and 6 → the step shifts later by 5 cycles.
- Priority and clamp:
  - load=1, load_val=0xFF with MAX_COUNT=100 → q=100.
  - load=1 and clear=1 on the same edge → q=0 and ovf=0.
  - load on a step edge → q equals the clamped load_val with no step applied.
- Sticky ovf: after a wrap sets ovf, 20 further non-boundary steps leave ovf=1. A single clear pulse gives ovf=0 and q=0 on the next cycle.
